fifo_rd_engine: RTL and testbench
=================================

FIFO_RD_ENGINE -- requirements
Module: fifo_rd_engine

Interface
REQ-001 Parameter DWIDTH, default 8, width of FIFO and downstream data.
REQ-002 Parameter BURST_LEN, default 10, number of words read per started burst (range 1..65535).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-004 i_rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-005 i_rrst  input  1  reset, asynchronous, active-high.
REQ-006 i_start  input  1  one-cycle request to begin a burst; honoured only in IDLE.
REQ-007 i_fifo_data  input  DWIDTH  FIFO read data, valid the cycle after an accepted read.
REQ-008 i_fifo_empty  input  1  FIFO read-empty flag (w_rd_empty of FIFO_top).
REQ-009 o_rden  output  1  FIFO read enable (drives i_rden of FIFO_top).
REQ-010 o_data  output  DWIDTH  downstream data.
REQ-011 o_valid  output  1  downstream data valid.
REQ-012 i_ready  input  1  downstream ready; word transfers when o_valid && i_ready.
REQ-013 o_busy  output  1  high in any state other than IDLE.
REQ-014 o_done  output  1  one-cycle pulse when a burst has been fully delivered.
REQ-015 o_count  output  16  total words delivered downstream since reset, wraps 65535->0.

Function
REQ-016 FSM states SHALL be IDLE, READ, DRAIN.
REQ-017 Transitions: IDLE->READ on i_start; READ->DRAIN when the BURST_LEN-th read is issued; DRAIN->IDLE when the skid buffer is empty and no read is in flight, pulsing o_done on that cycle.
REQ-018 i_start outside IDLE SHALL be ignored (no queuing).
REQ-019 o_rden SHALL be high only in READ, when i_fifo_empty is low, issued count < BURST_LEN, and buffer occupancy plus in-flight reads < 2; o_rden is combinational from registered state and i_fifo_empty.
REQ-020 FIFO read latency is exactly 1 cycle: i_fifo_data is captured into the buffer the cycle after o_rden was high.
REQ-021 Data SHALL pass through a 2-entry skid buffer; o_data/o_valid are registered at its head; order preserved.
REQ-022 With i_ready held high and the FIFO never empty, throughput SHALL be one word per cycle after a 2-cycle first-word latency (o_rden cycle N, o_valid cycle N+2).
REQ-023 o_data SHALL hold stable while o_valid && !i_ready.
REQ-024 Simultaneous buffer push and pop SHALL keep occupancy unchanged with no loss or duplication.
REQ-025 i_fifo_empty rising mid-burst SHALL stall reads without leaving READ; reads resume when it falls.
REQ-026 Issued and delivered counters are 16-bit; o_count increments on each downstream transfer and wraps.
REQ-027 The block SHALL never assert o_rden when i_fifo_empty is high (no underflow reads).

Reset
REQ-028 While i_rrst is high: state IDLE, o_rden 0, o_valid 0, o_data 0, o_busy 0, o_done 0, o_count 0, buffer and in-flight flag cleared.
REQ-029 Reset asserted mid-burst SHALL abort immediately; any in-flight FIFO word is discarded; no o_done pulse.
REQ-030 After reset deassertion the block SHALL wait in IDLE for a new i_start.

Structure
REQ-031 The FSM state enum and default DWIDTH/BURST_LEN constants SHALL live in pkg_graybin alongside the existing DEPTH constant.
REQ-032 The 2-entry buffer SHALL be a sub-module fifo_rd_skid (push, pop, data, occupancy) instantiated once.
REQ-033 The top integrates with FIFO_top read port only; no clock-domain crossing inside this block.

Verification
REQ-034 Reset then i_start with FIFO pre-loaded 10 words (1..10), i_ready=1 -> ten o_valid beats carrying 1..10, o_done one pulse, o_count=10.
REQ-035 Burst with i_ready low for 5 cycles after first word -> o_data holds 1, o_rden drops after occupancy reaches 2, no words lost or duplicated.
REQ-036 FIFO holding 3 words, BURST_LEN=10, 7 more written 20 cycles later -> READ stalls with o_rden=0 while empty, completes all 10 in order.
REQ-037 i_start pulsed again during READ -> ignored; exactly one o_done and BURST_LEN words.
REQ-038 i_rrst asserted after 4 words delivered -> all outputs 0 within same cycle, state IDLE, no o_done; next burst restarts cleanly, o_count counts from 0.
REQ-039 o_count preset near wrap by 65530 delivered words, burst of 10 -> o_count ends at 4.

Source files
------------

// File: rtl/pkg_graybin.sv
// Shared constants and types for the gray/binary FIFO and its read engine.
// Holds FIFO depth, read-engine defaults and the read FSM state encoding.
package pkg_graybin;

  localparam int DEPTH = 16;

  localparam int DEF_DWIDTH = 8;
  localparam int DEF_BURST_LEN = 10;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  // Skid slots still committed once this cycle's pop retires.
  function automatic logic [1:0] slots_used(
    input logic [1:0] occ,
    input logic       inflight,
    input logic       pop
  );
    return occ + {1'b0, inflight} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer between the FIFO read port and the consumer.
// The head register drives the consumer directly; order is preserved.
module fifo_rd_skid
  import pkg_graybin::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] data,
  output logic              valid,
  output logic [1:0]        occupancy
);

  logic [DWIDTH-1:0] head;
  logic [DWIDTH-1:0] tail;
  logic [1:0]        occ;
  logic              pop_ok;
  logic              push_ok;

  assign pop_ok  = pop && (occ != 2'd0);
  assign push_ok = push && ((occ != 2'd2) || pop_ok);

  // Shift data toward the head on pop; land new words in the first free slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (occ == 2'd0) begin
            head <= push_data;
          end else begin
            tail <= push_data;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head <= tail;
            tail <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign data      = head;
  assign valid     = (occ != 2'd0);
  assign occupancy = occ;

endmodule

// File: rtl/fifo_rd_engine.sv
// Burst read engine for the FIFO_top read port.
// Issues BURST_LEN reads per start and streams words through a skid buffer.
module fifo_rd_engine
  import pkg_graybin::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              i_rclk,
  input  logic              i_rrst,
  input  logic              i_start,
  input  logic [DWIDTH-1:0] i_fifo_data,
  input  logic              i_fifo_empty,
  output logic              o_rden,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_count
);

  localparam logic [CNT_W-1:0] BLEN = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  rd_state_t        state;
  rd_state_t        nxt;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] count;
  logic             inflight;
  logic             rden;
  logic             done;
  logic             pop;
  logic [1:0]       occ;
  logic [1:0]       slots;

  assign pop   = o_valid && i_ready;
  // A slot being popped this cycle is free for the next read,
  // which keeps a one-word-per-cycle stream going.
  assign slots = slots_used(occ, inflight, pop);

  fifo_rd_skid #(
    .DWIDTH(DWIDTH)
  ) u_skid (
    .clk       (i_rclk),
    .rst       (i_rrst),
    .push      (inflight),
    .push_data (i_fifo_data),
    .pop       (pop),
    .data      (o_data),
    .valid     (o_valid),
    .occupancy (occ)
  );

  // Next state, read enable and completion pulse.
  always_comb begin
    nxt  = state;
    rden = 1'b0;
    done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_start) begin
          nxt = ST_READ;
        end
      end
      ST_READ: begin
        rden = !i_fifo_empty
            && (issued < BLEN)
            && (slots < 2'd2);
        if (rden && (issued == LAST)) begin
          nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((occ == 2'd0) && !inflight) begin
          done = 1'b1;
          nxt  = ST_IDLE;
        end
      end
      default: begin
        nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_rclk or posedge i_rrst) begin
    if (i_rrst) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Issue/delivery counters and the one-cycle read-latency tracker.
  always_ff @(posedge i_rclk or posedge i_rrst) begin
    if (i_rrst) begin
      issued   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rden;
      if (state == ST_IDLE) begin
        issued <= '0;
      end else if (rden) begin
        issued <= issued + 1'b1;
      end
      if (pop) begin
        count <= count + 1'b1;
      end
    end
  end

  assign o_rden  = rden;
  assign o_done  = done;
  assign o_busy  = (state != ST_IDLE);
  assign o_count = count;

endmodule

// File: tb/tb_fifo_rd_engine.sv
// Directed bench for fifo_rd_engine with a small FIFO read-port model.
// A second long-burst instance exercises delivered-count wrap.
module tb_fifo_rd_engine;

  localparam int DW  = 8;
  localparam int BL  = 10;
  localparam int BLB = 32770;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic          ready;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          rden;
  logic [DW-1:0] data;
  logic          valid;
  logic          busy;
  logic          done;
  logic [15:0]   count;

  fifo_rd_engine #(
    .DWIDTH(DW),
    .BURST_LEN(BL)
  ) dut (
    .i_rclk       (clk),
    .i_rrst       (rst),
    .i_start      (start),
    .i_fifo_data  (fifo_data),
    .i_fifo_empty (fifo_empty),
    .o_rden       (rden),
    .o_data       (data),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_busy       (busy),
    .o_done       (done),
    .o_count      (count)
  );

  logic          rst_b;
  logic          start_b;
  logic          empty_b;
  logic          ready_b;
  logic [DW-1:0] fifo_data_b = '0;
  logic [15:0]   rptr_b = '0;
  logic          rden_b;
  logic [DW-1:0] data_b;
  logic          valid_b;
  logic          busy_b;
  logic          done_b;
  logic [15:0]   count_b;

  assign empty_b = 1'b0;
  assign ready_b = 1'b1;

  fifo_rd_engine #(
    .DWIDTH(DW),
    .BURST_LEN(BLB)
  ) dut_b (
    .i_rclk       (clk),
    .i_rrst       (rst_b),
    .i_start      (start_b),
    .i_fifo_data  (fifo_data_b),
    .i_fifo_empty (empty_b),
    .o_rden       (rden_b),
    .o_data       (data_b),
    .o_valid      (valid_b),
    .i_ready      (ready_b),
    .o_busy       (busy_b),
    .o_done       (done_b),
    .o_count      (count_b)
  );

  always @(posedge clk) begin
    if (rden_b) begin
      fifo_data_b <= rptr_b[DW-1:0];
      rptr_b      <= rptr_b + 16'd1;
    end
  end

  // FIFO read-port model for the main instance: 1-cycle read latency.
  logic [DW-1:0] mem [0:127];
  int wp = 0;
  int rp = 0;
  logic flush = 1'b0;

  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (flush) begin
      rp <= wp;
    end else if (rden) begin
      fifo_data <= mem[rp];
      rp        <= rp + 1;
    end
  end

  // Cycle counter and delivery monitor.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] got[$];
  logic clr = 1'b0;
  int done_cnt = 0;
  int underflow = 0;
  int rden_cnt = 0;
  int first_rden = 0;
  int first_vld = 0;
  int last_xfer = 0;
  bit seen_vld = 1'b0;

  always @(negedge clk) begin
    if (clr) begin
      got.delete();
      done_cnt  <= 0;
      underflow <= 0;
      rden_cnt  <= 0;
      seen_vld  <= 1'b0;
    end else begin
      if (rden && fifo_empty) underflow <= underflow + 1;
      if (rden) begin
        if (rden_cnt == 0) first_rden <= cyc;
        rden_cnt <= rden_cnt + 1;
      end
      if (valid && !seen_vld) begin
        seen_vld  <= 1'b1;
        first_vld <= cyc;
      end
      if (valid && ready) begin
        got.push_back(data);
        last_xfer <= cyc;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wp] = DW'(first + i);
      wp = wp + 1;
    end
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_words(input string tag, input int first,
                           input int n);
    chk({tag, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      chk(tag, got[i], DW'(first + i));
    end
  endtask

  // Long-burst instance: two bursts of 32770 words wrap o_count to 4.
  logic [15:0] b_cnt1 = '0;
  logic [15:0] b_cnt2 = '0;
  bit b_ok1 = 1'b0;
  bit b_ok2 = 1'b0;
  bit b_fin = 1'b0;

  initial begin
    rst_b   = 1'b1;
    start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1 start_b = 1'b1;
      @(posedge clk);
      #1 start_b = 1'b0;
      for (int i = 0; i < BLB + 100; i++) begin
        @(negedge clk);
        if (done_b) begin
          if (k == 0) b_ok1 = 1'b1;
          else        b_ok2 = 1'b1;
          break;
        end
      end
      if (k == 0) b_cnt1 = count_b;
      else        b_cnt2 = count_b;
    end
    b_fin = 1'b1;
  end

  bit ok;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rden",  rden,  0);
    chk("rst_valid", valid, 0);
    chk("rst_data",  data,  0);
    chk("rst_busy",  busy,  0);
    chk("rst_done",  done,  0);
    chk("rst_count", count, 0);
    rst = 1'b0;

    // Full-rate burst of 1..10.
    load(1, 10);
    clear_mon();
    pulse_start();
    wait_done(40, ok);
    chk("t1_done_seen", ok, 1);
    repeat (3) @(negedge clk);
    chk_words("t1_word", 1, 10);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_count", count, 10);
    chk("t1_latency", first_vld - first_rden, 2);
    chk("t1_span", last_xfer - first_vld, 9);
    chk("t1_busy", busy, 0);

    // Consumer stalls for 5 cycles on the first word.
    load(11, 10);
    clear_mon();
    ready = 1'b0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t2_valid_seen", ok, 1);
    chk("t2_first_data", data, 11);
    repeat (4) @(negedge clk);
    chk("t2_hold_data", data, 11);
    chk("t2_hold_valid", valid, 1);
    chk("t2_stall_rden", rden, 0);
    chk("t2_reads_issued", rden_cnt, 2);
    @(posedge clk);
    #1 ready = 1'b1;
    wait_done(40, ok);
    chk("t2_done_seen", ok, 1);
    repeat (3) @(negedge clk);
    chk_words("t2_word", 11, 10);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_count", count, 20);
    chk("t2_underflow", underflow, 0);

    // FIFO runs dry after 3 words; remainder arrives 20 cycles later.
    load(21, 3);
    clear_mon();
    pulse_start();
    repeat (20) @(negedge clk);
    chk("t3_busy", busy, 1);
    chk("t3_stall_rden", rden, 0);
    chk("t3_partial", got.size(), 3);
    @(posedge clk);
    #1 load(24, 7);
    wait_done(40, ok);
    chk("t3_done_seen", ok, 1);
    repeat (3) @(negedge clk);
    chk_words("t3_word", 21, 10);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_count", count, 30);
    chk("t3_underflow", underflow, 0);

    // Second start during READ must not queue another burst.
    load(31, 10);
    clear_mon();
    pulse_start();
    repeat (2) @(posedge clk);
    chk("t4_busy_at_restart", busy, 1);
    pulse_start();
    wait_done(40, ok);
    chk("t4_done_seen", ok, 1);
    repeat (15) @(negedge clk);
    chk_words("t4_word", 31, 10);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_busy", busy, 0);
    chk("t4_count", count, 40);

    // Reset mid-burst after 4 words delivered.
    load(41, 10);
    clear_mon();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (count == 16'd44) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_four_seen", ok, 1);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_rden",  rden,  0);
    chk("t5_rst_valid", valid, 0);
    chk("t5_rst_data",  data,  0);
    chk("t5_rst_busy",  busy,  0);
    chk("t5_rst_done",  done,  0);
    chk("t5_rst_count", count, 0);
    do_flush();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_idle", busy, 0);
    load(51, 10);
    clear_mon();
    pulse_start();
    wait_done(40, ok);
    chk("t5_done_seen", ok, 1);
    repeat (3) @(negedge clk);
    chk_words("t5_word", 51, 10);
    chk("t5_count", count, 10);
    chk("t5_done_cnt", done_cnt, 1);

    // Delivered-count wrap on the long-burst instance.
    for (int i = 0; i < 70000; i++) begin
      if (b_fin) break;
      @(negedge clk);
    end
    chk("wrap_finished", b_fin, 1);
    chk("wrap_done1", b_ok1, 1);
    chk("wrap_count1", b_cnt1, 32770);
    chk("wrap_done2", b_ok2, 1);
    chk("wrap_count2", b_cnt2, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
